// File: rtl/inv_mix_columns_iter_if.sv
// Handshake bundle for the iterative InvMixColumns engine: input state
// channel, output state channel and the busy indicator.
interface inv_mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  // Producer/consumer side that feeds states in and drains results.
  modport master (
    output in_valid,
    output state_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  state_out,
    input  busy
  );

  // Engine side.
  modport slave (
    input  in_valid,
    input  state_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output state_out,
    output busy
  );
endinterface

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns engine. A captured 128-bit state is transformed
// in place, COLS_PER_CYCLE columns per clock in column order 0..3, and the
// finished state is offered on a valid/ready output. Byte s(r,c) sits at
// state[127-8*(4c+r) -: 8], so each column is a 32-bit word with row 0 in
// its most significant byte.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  inv_mix_columns_iter_if.slave  bus
);

  // Only divisors of four give a whole number of column steps.
  generate
    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4))) begin : g_bad_param
      $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // GF(2^8) doubling modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] a);
    logic [7:0] r;
    if (a[7]) begin
      r = {a[6:0], 1'b0} ^ 8'h1B;
    end else begin
      r = {a[6:0], 1'b0};
    end
    return r;
  endfunction

  // Multiples 09/0B/0D/0E built from the shared x2/x4/x8 chain.
  function automatic logic [7:0] mul9(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // One column of InvMixColumns; row 0 is the top byte of the word.
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
    b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
    b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
    b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    return {b0, b1, b2, b3};
  endfunction

  logic [1:0]   fsm_q, fsm_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] state_out_q, state_out_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  logic [2:0]   lo_s;
  logic [2:0]   hi_s;
  logic         last_s;
  logic [127:0] mixed_s;

  assign lo_s   = {1'b0, cnt_q};
  assign hi_s   = lo_s + STEP;
  assign last_s = (hi_s == 3'd4);

  // Working state with the columns of the current step replaced.
  always_comb begin
    mixed_s = data_q;
    for (int c = 0; c < 4; c++) begin
      if ((3'(c) >= lo_s) && (3'(c) < hi_s)) begin
        mixed_s[127-32*c -: 32] = inv_col(data_q[127-32*c -: 32]);
      end else begin
        mixed_s[127-32*c -: 32] = data_q[127-32*c -: 32];
      end
    end
  end

  // Sequencer: capture in IDLE, step columns in CALC, hold result in DONE.
  // Handshake flags are computed alongside the state so they leave flops.
  always_comb begin
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    state_out_d = state_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          data_d      = bus.state_in;
          cnt_d       = 2'd0;
          fsm_d       = ST_CALC;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
        end else begin
          fsm_d       = ST_IDLE;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
        out_valid_d = 1'b0;
      end
      ST_CALC: begin
        data_d = mixed_s;
        cnt_d  = cnt_q + STEP[1:0];
        if (last_s) begin
          fsm_d       = ST_DONE;
          state_out_d = mixed_s;
          out_valid_d = 1'b1;
        end else begin
          fsm_d       = ST_CALC;
          out_valid_d = 1'b0;
        end
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          fsm_d       = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          fsm_d       = ST_DONE;
          out_valid_d = 1'b1;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        cnt_d       = 2'd0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output flops; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= 2'd0;
      data_q      <= 128'd0;
      state_out_q <= 128'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      state_out_q <= state_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;
  assign bus.busy      = busy_q;

endmodule
